// File: rtl/sdram_pattern_tester.sv
`default_nettype none
// ============================================================================
// Module   : sdram_pattern_tester
// Purpose  : Avalon-MM SDRAM window tester. Burst-writes an address-derived
//            pattern over a word window, burst-reads it back and compares
//            every returned beat. Reports mismatch count, first failing
//            address/data and completed passes. Optionally loops forever,
//            inverting the pattern on odd passes for soak testing.
// Ports    : clock_i/reset_i        - clock, synchronous active-high reset
//            start_i/continuous_i   - run request, loop-mode select
//            address_o/burstcount_o - Avalon word address, fixed burst size
//            read_o/write_o         - Avalon read/write requests
//            writedata_o/byteenable_o, waitrequest_i
//            readdata_i/readdatavalid_i - returned read beats
//            busy_o/done_o          - run status
//            pass_count_o/error_count_o/first_error_*_o - results
// Revision : 1.0 - initial release
// ============================================================================
module sdram_pattern_tester #(
  parameter int                    ADDR_WIDTH    = 29,
  parameter int                    DATA_WIDTH    = 64,
  parameter int                    BURST_LEN     = 8,
  parameter logic [ADDR_WIDTH-1:0] START_ADDRESS = 'h0700_0000,
  parameter int                    WORD_COUNT    = 1024,
  parameter logic [63:0]           SEED          = 64'hDEAD_BEEF_CAFE_BABE
) (
  input  logic                      clock_i,
  input  logic                      reset_i,
  input  logic                      start_i,
  input  logic                      continuous_i,
  output logic [ADDR_WIDTH-1:0]     address_o,
  output logic [7:0]                burstcount_o,
  input  logic                      waitrequest_i,
  input  logic [DATA_WIDTH-1:0]     readdata_i,
  input  logic                      readdatavalid_i,
  output logic                      read_o,
  output logic [DATA_WIDTH-1:0]     writedata_o,
  output logic [DATA_WIDTH/8-1:0]   byteenable_o,
  output logic                      write_o,
  output logic                      busy_o,
  output logic                      done_o,
  output logic [15:0]               pass_count_o,
  output logic [31:0]               error_count_o,
  output logic [ADDR_WIDTH-1:0]     first_error_address_o,
  output logic [DATA_WIDTH-1:0]     first_error_data_o
);

  localparam int                    NUM_BURSTS = WORD_COUNT / BURST_LEN;
  localparam logic [7:0]            LAST_BEAT  = 8'(BURST_LEN - 1);
  localparam logic [31:0]           LAST_BURST = 32'(NUM_BURSTS - 1);
  localparam logic [ADDR_WIDTH-1:0] BURST_STEP = ADDR_WIDTH'(BURST_LEN);
  localparam logic [DATA_WIDTH-1:0] SEED_W     = DATA_WIDTH'(SEED);

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_WRITE       = 3'd1,
    S_READ_REQ    = 3'd2,
    S_READ_DATA   = 3'd3,
    S_CHECK_DRAIN = 3'd4,
    S_DONE        = 3'd5
  } state_t;

  // Expected word at address a; odd passes use the inverted pattern so
  // stuck-at bits are exercised in both polarities during soak runs.
  function automatic logic [DATA_WIDTH-1:0] pattern(input logic [ADDR_WIDTH-1:0] addr,
                                                    input logic                  invert);
    logic [DATA_WIDTH-1:0] p;
    p = SEED_W ^ DATA_WIDTH'(addr);
    return invert ? ~p : p;
  endfunction

  state_t                  state_q;
  logic [ADDR_WIDTH-1:0]   base_q;
  logic [7:0]              beat_q;
  logic [31:0]             burst_cnt_q;
  logic                    cont_q;
  logic [ADDR_WIDTH-1:0]   address_q;
  logic [DATA_WIDTH-1:0]   writedata_q;
  logic                    write_q;
  logic                    read_q;
  logic                    done_q;
  logic [15:0]             pass_count_q;
  logic [31:0]             error_count_q;
  logic [ADDR_WIDTH-1:0]   fe_addr_q;
  logic [DATA_WIDTH-1:0]   fe_data_q;

  // Registered compare result, applied to the counters one cycle later.
  logic                    mism_q;
  logic [ADDR_WIDTH-1:0]   mism_addr_q;
  logic [DATA_WIDTH-1:0]   mism_data_q;

  logic [ADDR_WIDTH-1:0]   beat_addr_d;
  logic [ADDR_WIDTH-1:0]   next_beat_addr_d;
  logic [ADDR_WIDTH-1:0]   next_base_d;
  logic                    last_beat_d;
  logic                    last_burst_d;

  // Address arithmetic wraps naturally at ADDR_WIDTH bits.
  assign beat_addr_d      = base_q + ADDR_WIDTH'(beat_q);
  assign next_beat_addr_d = base_q + ADDR_WIDTH'(beat_q + 8'd1);
  assign next_base_d      = base_q + BURST_STEP;
  assign last_beat_d      = (beat_q == LAST_BEAT);
  assign last_burst_d     = (burst_cnt_q == LAST_BURST);

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q       <= S_IDLE;
      base_q        <= '0;
      beat_q        <= '0;
      burst_cnt_q   <= '0;
      cont_q        <= 1'b0;
      address_q     <= '0;
      writedata_q   <= '0;
      write_q       <= 1'b0;
      read_q        <= 1'b0;
      done_q        <= 1'b0;
      pass_count_q  <= '0;
      error_count_q <= '0;
      fe_addr_q     <= '0;
      fe_data_q     <= '0;
      mism_q        <= 1'b0;
      mism_addr_q   <= '0;
      mism_data_q   <= '0;
    end else begin
      mism_q <= 1'b0;

      // Second stage of the compare: count (saturating) and capture first.
      if (mism_q) begin
        if (error_count_q != 32'hFFFF_FFFF) begin
          error_count_q <= error_count_q + 32'd1;
        end
        if (error_count_q == 32'd0) begin
          fe_addr_q <= mism_addr_q;
          fe_data_q <= mism_data_q;
        end
      end

      case (state_q)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            error_count_q <= '0;
            fe_addr_q     <= '0;
            fe_data_q     <= '0;
            pass_count_q  <= '0;
            done_q        <= 1'b0;
            cont_q        <= continuous_i;
            base_q        <= START_ADDRESS;
            beat_q        <= '0;
            burst_cnt_q   <= '0;
            address_q     <= START_ADDRESS;
            writedata_q   <= pattern(START_ADDRESS, 1'b0);
            write_q       <= 1'b1;
            state_q       <= S_WRITE;
          end
        end

        S_WRITE: begin
          if (write_q && !waitrequest_i) begin
            if (last_beat_d) begin
              beat_q <= '0;
              if (last_burst_d) begin
                burst_cnt_q <= '0;
                base_q      <= START_ADDRESS;
                address_q   <= START_ADDRESS;
                write_q     <= 1'b0;
                read_q      <= 1'b1;
                state_q     <= S_READ_REQ;
              end else begin
                // Back-to-back bursts: next burst's first beat is ready now.
                burst_cnt_q <= burst_cnt_q + 32'd1;
                base_q      <= next_base_d;
                address_q   <= next_base_d;
                writedata_q <= pattern(next_base_d, pass_count_q[0]);
              end
            end else begin
              beat_q      <= beat_q + 8'd1;
              writedata_q <= pattern(next_beat_addr_d, pass_count_q[0]);
            end
          end
        end

        S_READ_REQ: begin
          if (read_q && !waitrequest_i) begin
            read_q  <= 1'b0;
            state_q <= S_READ_DATA;
          end
        end

        S_READ_DATA: begin
          if (readdatavalid_i) begin
            mism_q      <= (readdata_i != pattern(beat_addr_d, pass_count_q[0]));
            mism_addr_q <= beat_addr_d;
            mism_data_q <= readdata_i;
            if (last_beat_d) begin
              beat_q <= '0;
              base_q <= next_base_d;
              if (last_burst_d) begin
                burst_cnt_q <= '0;
                state_q     <= S_CHECK_DRAIN;
              end else begin
                // Only one read burst is ever outstanding.
                burst_cnt_q <= burst_cnt_q + 32'd1;
                address_q   <= next_base_d;
                read_q      <= 1'b1;
                state_q     <= S_READ_REQ;
              end
            end else begin
              beat_q <= beat_q + 8'd1;
            end
          end
        end

        S_CHECK_DRAIN: begin
          // The last beat's compare lands this cycle via mism_q.
          pass_count_q <= pass_count_q + 16'd1;
          if (cont_q) begin
            base_q      <= START_ADDRESS;
            beat_q      <= '0;
            burst_cnt_q <= '0;
            address_q   <= START_ADDRESS;
            writedata_q <= pattern(START_ADDRESS, ~pass_count_q[0]);
            write_q     <= 1'b1;
            state_q     <= S_WRITE;
          end else begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign address_o             = address_q;
  assign burstcount_o          = 8'(BURST_LEN);
  assign byteenable_o          = '1;
  assign read_o                = read_q;
  assign write_o               = write_q;
  assign writedata_o           = writedata_q;
  assign busy_o                = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done_o                = done_q;
  assign pass_count_o          = pass_count_q;
  assign error_count_o         = error_count_q;
  assign first_error_address_o = fe_addr_q;
  assign first_error_data_o    = fe_data_q;

endmodule
`default_nettype wire
